// File: rtl/ppt_ctrl_regs.sv
// ============================================================================
// Module   : ppt_ctrl_regs
// Brief    : Register file and run-control FSM for the programmable pulse
//            train. Writes go to staging registers; a start copies them to the
//            active outputs. Optional macro PPT_IRQ_EN adds a completion irq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppt_ctrl_regs #(
    parameter logic [15:0] RST_PERIOD = 16'd4,
    parameter logic [15:0] RST_WIDTH  = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    input  logic [15:0] pulse_count,
    output logic        run,
    output logic [15:0] period,
    output logic [15:0] width,
    output logic [4:0]  clk_div
`ifdef PPT_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [3:0] c_ADDR_CTRL     = 4'h0;
    localparam logic [3:0] c_ADDR_STATUS   = 4'h1;
    localparam logic [3:0] c_ADDR_PER_LO   = 4'h2;
    localparam logic [3:0] c_ADDR_PER_HI   = 4'h3;
    localparam logic [3:0] c_ADDR_WID_LO   = 4'h4;
    localparam logic [3:0] c_ADDR_WID_HI   = 4'h5;
    localparam logic [3:0] c_ADDR_TGT_LO   = 4'h6;
    localparam logic [3:0] c_ADDR_TGT_HI   = 4'h7;
    localparam logic [3:0] c_ADDR_CNT_LO   = 4'h8;
    localparam logic [3:0] c_ADDR_CNT_HI   = 4'h9;
    localparam logic [3:0] c_ADDR_CLK_DIV  = 4'hA;

    localparam logic [4:0] c_RST_CLK_DIV   = 5'd1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic        r_continuous;
    logic        r_done;
    logic        r_cfg_err;
    logic [15:0] r_stg_period;
    logic [15:0] r_stg_width;
    logic [15:0] r_stg_target;
    logic [4:0]  r_stg_clk_div;
    logic [15:0] r_act_period;
    logic [15:0] r_act_width;
    logic [15:0] r_act_target;
    logic [4:0]  r_act_clk_div;
    logic [15:0] r_count_done;
    logic [7:0]  r_cnt_hi_snap;
    logic [7:0]  r_rd_data;

    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_stop;
    logic        w_cfg_bad;
    logic        w_target_hit;
    logic        w_busy;
    logic        w_irq_en_rd;
    logic [1:0]  w_state_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_capture;
    logic        w_load;
    logic [7:0]  w_rd_mux;

    assign w_ctrl_wr    = wr_en && (wr_addr == c_ADDR_CTRL);
    assign w_start      = w_ctrl_wr && wr_data[0];
    assign w_stop       = w_ctrl_wr && wr_data[1];
    assign w_cfg_bad    = (r_stg_period == 16'd0) || (r_stg_width == 16'd0) ||
                          (r_stg_width >= r_stg_period);
    assign w_target_hit = (pulse_count >= r_act_target);
    assign w_busy       = (r_state == c_ST_RUN);

    // Stop wins over both a simultaneous start and a simultaneous target hit.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_err_nxt   = r_cfg_err;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (w_stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_capture   = 1'b1;
                end else if (!r_continuous && w_target_hit) begin
                    w_state_nxt = c_ST_DONE;
                    w_capture   = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            c_ST_IDLE, c_ST_DONE: begin
                if (w_start && !w_stop) begin
                    w_done_nxt = 1'b0;
                    if (w_cfg_bad) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_err_nxt   = 1'b0;
                        w_load      = 1'b1;
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_count_done <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= w_err_nxt;
            if (w_capture) begin
                r_count_done <= pulse_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_continuous  <= 1'b0;
            r_stg_period  <= RST_PERIOD;
            r_stg_width   <= RST_WIDTH;
            r_stg_target  <= 16'd0;
            r_stg_clk_div <= c_RST_CLK_DIV;
        end else if (wr_en) begin
            case (wr_addr)
                c_ADDR_CTRL:    r_continuous        <= wr_data[2];
                c_ADDR_PER_LO:  r_stg_period[7:0]   <= wr_data;
                c_ADDR_PER_HI:  r_stg_period[15:8]  <= wr_data;
                c_ADDR_WID_LO:  r_stg_width[7:0]    <= wr_data;
                c_ADDR_WID_HI:  r_stg_width[15:8]   <= wr_data;
                c_ADDR_TGT_LO:  r_stg_target[7:0]   <= wr_data;
                c_ADDR_TGT_HI:  r_stg_target[15:8]  <= wr_data;
                c_ADDR_CLK_DIV: r_stg_clk_div       <= wr_data[4:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_period  <= RST_PERIOD;
            r_act_width   <= RST_WIDTH;
            r_act_target  <= 16'd0;
            r_act_clk_div <= c_RST_CLK_DIV;
        end else if (w_load) begin
            r_act_period  <= r_stg_period;
            r_act_width   <= r_stg_width;
            r_act_target  <= r_stg_target;
            r_act_clk_div <= r_stg_clk_div;
        end
    end

`ifdef PPT_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    logic w_irq_en_nxt;

    assign w_irq_en_nxt = w_ctrl_wr ? wr_data[3] : r_irq_en;
    assign w_irq_en_rd  = r_irq_en;
    assign irq          = r_irq;

    // irq follows the next value of done so it clears on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= w_done_nxt && w_irq_en_nxt;
        end
    end
`else
    assign w_irq_en_rd = 1'b0;
`endif

    always_comb begin
        w_rd_mux = 8'h00;
        case (rd_addr)
            c_ADDR_CTRL:    w_rd_mux = {4'b0000, w_irq_en_rd, r_continuous, 2'b00};
            c_ADDR_STATUS:  w_rd_mux = {5'b00000, r_cfg_err, r_done, w_busy};
            c_ADDR_PER_LO:  w_rd_mux = r_stg_period[7:0];
            c_ADDR_PER_HI:  w_rd_mux = r_stg_period[15:8];
            c_ADDR_WID_LO:  w_rd_mux = r_stg_width[7:0];
            c_ADDR_WID_HI:  w_rd_mux = r_stg_width[15:8];
            c_ADDR_TGT_LO:  w_rd_mux = r_stg_target[7:0];
            c_ADDR_TGT_HI:  w_rd_mux = r_stg_target[15:8];
            c_ADDR_CNT_LO:  w_rd_mux = r_count_done[7:0];
            c_ADDR_CNT_HI:  w_rd_mux = r_cnt_hi_snap;
            c_ADDR_CLK_DIV: w_rd_mux = {3'b000, r_stg_clk_div};
            default:        w_rd_mux = 8'h00;
        endcase
    end

    // Reading the low count byte freezes the high byte for the following read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data     <= 8'h00;
            r_cnt_hi_snap <= 8'h00;
        end else begin
            r_rd_data <= w_rd_mux;
            if (rd_addr == c_ADDR_CNT_LO) begin
                r_cnt_hi_snap <= r_count_done[15:8];
            end
        end
    end

    assign rd_data = r_rd_data;
    assign run     = w_busy;
    assign period  = r_act_period;
    assign width   = r_act_width;
    assign clk_div = r_act_clk_div;

endmodule

`default_nettype wire
